// File: rtl/de0_pkg.sv
// Shared definitions for the DE0 accumulator calculator.
//   opcode_e   : SW[3:0] opcode names
//   SEG_TABLE  : active-low 7-segment glyphs for 0..F (bit7 = DP, off)
//   hex_to_seg : nibble -> 8-bit segment pattern
package de0_pkg;

    typedef enum logic [3:0] {
        OP_INC   = 4'd0,
        OP_DEC   = 4'd1,
        OP_SHL   = 4'd2,
        OP_SHR   = 4'd3,
        OP_NOT   = 4'd4,
        OP_ADDI  = 4'd5,
        OP_SUBI  = 4'd6,
        OP_ANDI  = 4'd7,
        OP_SWAPB = 4'd8,
        OP_LOADI = 4'd12,
        OP_CLR   = 4'd15
    } opcode_e;

    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/de0_wrapper_button_conditioner.sv
// Push-button conditioner: synchroniser, debouncer and press-edge detector.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn_n      : raw active-low button pin
//   press      : one-cycle pulse on each debounced released->pressed edge
module button_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);
    import de0_pkg::*;

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   press_q, press_d;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign press    = press_q;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = ~btn_n;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end

        // The counter runs only while the synchronised input disagrees with
        // the accepted level; any agreement restarts the stability window.
        cnt_d = '0;
        db_d  = db_q;
        if (sync_out != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sync_out;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        press_d = db_d & ~db_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            press_q <= press_d;
        end
    end

endmodule

// File: rtl/de0_wrapper.sv
// DE0 board top: 16-bit accumulator calculator driven by two push-buttons.
//   CLOCK_50  : 50 MHz clock
//   KEY[2]    : asynchronous active-low reset; KEY[1:0] active-low buttons
//   SW[3:0]   : opcode; SW[9:4] : 6-bit immediate
//   LEDG      : {ACC==0, CARRY, EVCNT, SW[3:0]}
//   HEX0..3   : ACC nibbles as active-low 7-segment glyphs
module de0_wrapper #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       CLOCK_50,
    input  logic [2:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDG,
    output logic [7:0] HEX0,
    output logic [7:0] HEX1,
    output logic [7:0] HEX2,
    output logic [7:0] HEX3
);
    import de0_pkg::*;

    logic        rst_n;
    logic        press0, press1;
    logic [15:0] acc_q, acc_d;
    logic [15:0] breg_q, breg_d;
    logic        carry_q, carry_d;
    logic [3:0]  evcnt_q, evcnt_d;
    logic [15:0] imm;
    logic [16:0] wide;

    assign rst_n = KEY[2];
    assign imm   = {10'b0, SW[9:4]};

    button_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
        u_btn0 (.clk(CLOCK_50), .rst_n(rst_n), .btn_n(KEY[0]), .press(press0));

    button_conditioner #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
        u_btn1 (.clk(CLOCK_50), .rst_n(rst_n), .btn_n(KEY[1]), .press(press1));

    always_comb begin
        acc_d   = acc_q;
        breg_d  = breg_q;
        carry_d = carry_q;
        evcnt_d = evcnt_q;
        wide    = '0;

        // A swap wins over an opcode arriving in the same cycle.
        if (press1) begin
            acc_d  = breg_q;
            breg_d = acc_q;
        end else if (press0) begin
            carry_d = 1'b0;
            case (opcode_e'(SW[3:0]))
                OP_INC: begin
                    wide    = {1'b0, acc_q} + 17'd1;
                    acc_d   = wide[15:0];
                    carry_d = wide[16];
                end
                OP_DEC: begin
                    wide    = {1'b0, acc_q} - 17'd1;
                    acc_d   = wide[15:0];
                    carry_d = wide[16];
                end
                OP_SHL: begin
                    acc_d   = {acc_q[14:0], 1'b0};
                    carry_d = acc_q[15];
                end
                OP_SHR: begin
                    acc_d   = {1'b0, acc_q[15:1]};
                    carry_d = acc_q[0];
                end
                OP_NOT:   acc_d = ~acc_q;
                OP_ADDI: begin
                    wide    = {1'b0, acc_q} + {1'b0, imm};
                    acc_d   = wide[15:0];
                    carry_d = wide[16];
                end
                OP_SUBI: begin
                    wide    = {1'b0, acc_q} - {1'b0, imm};
                    acc_d   = wide[15:0];
                    carry_d = wide[16];
                end
                OP_ANDI:  acc_d = acc_q & {10'h3FF, SW[9:4]};
                OP_SWAPB: acc_d = {acc_q[7:0], acc_q[15:8]};
                OP_LOADI: acc_d = imm;
                OP_CLR:   acc_d = '0;
                default:  acc_d = acc_q;
            endcase
        end

        if (press0 || press1) begin
            evcnt_d = evcnt_q + 4'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            breg_q  <= '0;
            carry_q <= 1'b0;
            evcnt_q <= '0;
        end else begin
            acc_q   <= acc_d;
            breg_q  <= breg_d;
            carry_q <= carry_d;
            evcnt_q <= evcnt_d;
        end
    end

    assign LEDG = {(acc_q == 16'd0), carry_q, evcnt_q, SW[3:0]};
    assign HEX0 = hex_to_seg(acc_q[3:0]);
    assign HEX1 = hex_to_seg(acc_q[7:4]);
    assign HEX2 = hex_to_seg(acc_q[11:8]);
    assign HEX3 = hex_to_seg(acc_q[15:12]);

endmodule

// File: tb/tb_de0_wrapper.sv
// Directed bench for de0_wrapper with a behavioural reference model.
module tb_de0_wrapper;

    logic       CLOCK_50;
    logic [2:0] KEY;
    logic [9:0] SW;
    logic [9:0] LEDG;
    logic [7:0] HEX0, HEX1, HEX2, HEX3;

    de0_wrapper dut (
        .CLOCK_50(CLOCK_50), .KEY(KEY), .SW(SW), .LEDG(LEDG),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
    );

    // clock / reset
    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // reference model state
    logic [15:0] m_acc, m_breg;
    logic        m_carry;
    logic [3:0]  m_evcnt;

    // scoreboard: {HEX3, HEX2, HEX1, HEX0, LEDG}
    logic [41:0] exp_q[$];
    int n_compared   = 0;
    int n_mismatched = 0;

    function automatic logic [7:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    task automatic push_expected();
        logic [9:0] led;
        led = {m_acc == 16'd0, m_carry, m_evcnt, SW[3:0]};
        exp_q.push_back({glyph(m_acc[15:12]), glyph(m_acc[11:8]),
                         glyph(m_acc[7:4]), glyph(m_acc[3:0]), led});
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_outputs(input string tag);
        logic [41:0] e;
        e = exp_q.pop_front();
        check({tag, ".hex3"}, {8'h0, HEX3}, {8'h0, e[41:34]});
        check({tag, ".hex2"}, {8'h0, HEX2}, {8'h0, e[33:26]});
        check({tag, ".hex1"}, {8'h0, HEX1}, {8'h0, e[25:18]});
        check({tag, ".hex0"}, {8'h0, HEX0}, {8'h0, e[17:10]});
        check({tag, ".ledg"}, {6'h0, LEDG}, {6'h0, e[9:0]});
    endtask

    task automatic model_reset();
        m_acc = '0; m_breg = '0; m_carry = 1'b0; m_evcnt = '0;
    endtask

    task automatic apply_reset();
        KEY[2] = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        model_reset();
        KEY[2] = 1'b1;
        repeat (2) @(negedge CLOCK_50);
    endtask

    // Behavioural reference for one accepted press event.
    task automatic model_press(input bit p0, input bit p1);
        logic [15:0] imm;
        logic [15:0] t;
        imm = {10'b0, SW[9:4]};
        if (p1) begin
            t = m_acc; m_acc = m_breg; m_breg = t;
        end else if (p0) begin
            case (SW[3:0])
                4'd0:  begin m_carry = (m_acc == 16'hFFFF); m_acc = m_acc + 16'd1; end
                4'd1:  begin m_carry = (m_acc == 16'h0000); m_acc = m_acc - 16'd1; end
                4'd2:  begin m_carry = m_acc[15]; m_acc = m_acc << 1; end
                4'd3:  begin m_carry = m_acc[0];  m_acc = m_acc >> 1; end
                4'd4:  begin m_carry = 1'b0; m_acc = ~m_acc; end
                4'd5:  begin m_carry = (32'(m_acc) + 32'(imm)) > 32'hFFFF; m_acc = m_acc + imm; end
                4'd6:  begin m_carry = (imm > m_acc); m_acc = m_acc - imm; end
                4'd7:  begin m_carry = 1'b0; m_acc = m_acc & (16'hFFC0 | imm); end
                4'd8:  begin m_carry = 1'b0; m_acc = {m_acc[7:0], m_acc[15:8]}; end
                4'd12: begin m_carry = 1'b0; m_acc = imm; end
                4'd15: begin m_carry = 1'b0; m_acc = 16'd0; end
                default: m_carry = 1'b0;
            endcase
        end
        if (p0 || p1) m_evcnt = m_evcnt + 4'd1;
    endtask

    task automatic wait_evcnt(input logic [3:0] want);
        int n;
        n = 0;
        while (LEDG[7:4] !== want && n < 300) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("evcnt_arrival", {12'h0, LEDG[7:4]}, {12'h0, want});
    endtask

    // Press buttons in mask (bit0 = KEY[0], bit1 = KEY[1]) for 50 cycles (1 us).
    task automatic do_press(input logic [1:0] mask, input string tag);
        model_press(mask[0], mask[1]);
        push_expected();
        @(negedge CLOCK_50);
        KEY[1:0] = ~mask;
        repeat (50) @(negedge CLOCK_50);
        KEY[1:0] = 2'b11;
        wait_evcnt(m_evcnt);
        compare_outputs(tag);
        repeat (40) @(negedge CLOCK_50);
    endtask

    initial begin
        logic [3:0] ops [10];
        ops = '{4'd0, 4'd5, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd6, 4'd9, 4'd15};
        KEY = 3'b111;
        SW  = 10'd1;
        model_reset();

        // 1: reset state with SW=1
        apply_reset();
        push_expected();
        compare_outputs("reset");

        // 2: increment from zero
        SW = 10'd0;
        apply_reset();
        do_press(2'b01, "inc");

        // 3: swap with BREG
        do_press(2'b10, "swap");

        // 4: decrement through zero
        SW = 10'd1;
        do_press(2'b01, "dec_wrap");

        // 5: load immediate 0x3F
        SW = {6'h3F, 4'd12};
        do_press(2'b01, "load");

        // assorted opcodes with random immediates
        foreach (ops[i]) begin
            SW = {6'($urandom_range(0, 63)), ops[i]};
            do_press(2'b01, $sformatf("op%0d", ops[i]));
        end

        // 6: a 10-cycle glitch must be ignored
        SW = 10'd0;
        push_expected();
        KEY[0] = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        KEY[0] = 1'b1;
        repeat (60) @(negedge CLOCK_50);
        compare_outputs("short_press");

        // 7: both buttons together -> swap only, one event
        SW = {6'h15, 4'd5};
        do_press(2'b11, "both");

        // 8: reset mid-debounce discards the pending press
        KEY[0] = 1'b0;
        repeat (8) @(negedge CLOCK_50);
        KEY[2] = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        KEY[0] = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        model_reset();
        KEY[2] = 1'b1;
        push_expected();
        repeat (60) @(negedge CLOCK_50);
        compare_outputs("reset_mid_press");

        // BREG was cleared too: swapping leaves ACC at zero
        do_press(2'b10, "swap_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/de0_wrapper.md
Name: de0_wrapper

Overview:
- Top-level board block for the DE0 target.
- Conditions two push-buttons and uses SW[3:0] as an opcode to drive a 16-bit accumulator calculator.
- Shows the accumulator on four 7-segment digits and status on the green LEDs.
- Sits directly on the board pins; no other logic sits between it and the board I/O.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable clock cycles required before a button level is accepted.
- SYNC_STAGES, 2, flip-flop stages in each button synchroniser.

Ports:
- CLOCK_50  input  1  single 50 MHz system clock.
- KEY  input  3  KEY[2] is the reset (nReset): asynchronous, active-low. KEY[1:0] are push-buttons, active-low (0 = pressed).
- SW  input  10  slide switches. SW[3:0] is the opcode; SW[9:4] is a 6-bit immediate.
- LEDG  output  10  status LEDs, active-high.
- HEX0  output  8  7-seg digit for ACC[3:0]; bit7 = DP, bits6:0 = gfedcba; all active-low.
- HEX1  output  8  7-seg digit for ACC[7:4], same encoding.
- HEX2  output  8  7-seg digit for ACC[11:8], same encoding.
- HEX3  output  8  7-seg digit for ACC[15:12], same encoding.

Behaviour:
Reset (KEY[2]=0) asynchronously clears:
- ACC = 0, BREG = 0, CARRY = 0, EVCNT = 0.
- All synchroniser and debouncer state, with debounced level = released.

Button conditioning (per KEY[0], KEY[1]):
- Invert to active-high, then pass through SYNC_STAGES flip-flops.
- Debounced level changes only after the synchronised input has held a new value for DEBOUNCE_CYCLES consecutive cycles.
- A released-to-pressed transition of the debounced level yields one 1-cycle press pulse.
- Pulse latency from the pin edge is SYNC_STAGES + DEBOUNCE_CYCLES cycles (±1).
- Pulses shorter than DEBOUNCE_CYCLES produce nothing.
- A held button produces exactly one pulse.

On a press0 pulse, execute SW[3:0] (sampled that cycle); ACC updates on the next clock edge:
- 0: ACC+1
- 1: ACC-1
- 2: ACC<<1
- 3: ACC>>1 (logical)
- 4: ~ACC
- 5: ACC + zext(SW[9:4])
- 6: ACC - zext(SW[9:4])
- 7: ACC & {10'h3FF, SW[9:4]}
- 8: byte swap {ACC[7:0], ACC[15:8]}
- 12: load zext(SW[9:4])
- 15: clear to 0
- 9, 10, 11, 13, 14: no change.

CARRY rules:
- Opcodes 0, 5: carry-out of bit 15.
- Opcodes 1, 6: borrow out of bit 15.
- Opcode 2: shifted-out bit 15.
- Opcode 3: shifted-out bit 0.
- All other opcodes: cleared to 0.

On a press1 pulse: swap ACC and BREG. CARRY is unchanged.

Simultaneous press0 and press1 in the same cycle:
- Only the swap is performed.
- EVCNT increments once.

EVCNT (4-bit, wraps 15→0) increments on any cycle with at least one press pulse.

LEDG (combinational):
- [3:0] = SW[3:0] (live).
- [7:4] = EVCNT.
- [8] = CARRY.
- [9] = (ACC==0).

HEX (combinational from ACC):
- Standard hex glyphs, DP always off (bit7=1).
- Digit codes, 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.

Other rules:
- Arithmetic is 16-bit modulo 2^16.
- SW has no synchroniser; it is quasi-static and is sampled only on the press0 cycle.
- Reset asserted mid-debounce discards the pending press.

Decomposition:
- Package de0_pkg holds:
  - typedef opcode_e with the named opcodes;
  - the 16-entry 7-seg constant table;
  - function hex_to_seg(nibble) returning 8 bits.
- One sub-module, button_conditioner: synchroniser + debouncer + edge detector; parameters SYNC_STAGES and DEBOUNCE_CYCLES. Instantiate it twice.

Test Plan:
1. Reset, SW=1 → after reset: HEX0..HEX3 = 8'hC0, LEDG = 10'h201.
2. Reset, SW=0, one 1 µs press0 → ACC=1: HEX0=8'hF9, HEX1..HEX3=8'hC0, LEDG=10'h010.
3. Then one press1 → ACC=0, BREG=1: all HEX = 8'hC0, LEDG=10'h220.
4. Then SW=1, press0 → ACC=16'hFFFF: all HEX = 8'h8E, LEDG[8]=1, LEDG[9]=0, LEDG[7:4]=3.
5. SW=12 with SW[9:4]=6'h3F, press0 → ACC=16'h003F: HEX0=8'h8E, HEX1=8'hB0, HEX2=HEX3=8'hC0.
6. Button pulse of 10 cycles (< DEBOUNCE_CYCLES) → no change in ACC or EVCNT.
7. Both buttons pressed in the same cycle → swap only, EVCNT +1.
8. Reset pulse mid-press → all state returns to reset values and no pulse follows.
